// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 keyboard event queue: prefix bytes,
// parser states and the packed event word stored in the FIFO.
package kbd_pkg;

  localparam logic [7:0] KBD_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  // 10-bit event word {code, ext, release}
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } kbd_evt_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous event FIFO with a registered head word. The head register is
// loaded with whatever will sit at the read pointer after this edge, so the
// consumer sees flop outputs that only change on a push into an empty FIFO
// or on a pop.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  kbd_evt_t               din,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output kbd_evt_t               head,
  output logic                   head_valid
);

  localparam int AW = $clog2(DEPTH);

  kbd_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]     count_n;
  logic            do_push, do_pop;
  kbd_evt_t        head_n;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  // next occupancy and next head word
  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + (AW+1)'(1);
      2'b01:   count_n = count - (AW+1)'(1);
      default: count_n = count;
    endcase
    head_n = '0;
    if (count_n != '0) begin
      if (do_push && (wr_ptr == rd_ptr_n)) head_n = din;
      else                                 head_n = mem[rd_ptr_n];
    end
  end

  // pointers, occupancy and registered head
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      head       <= head_n;
      head_valid <= (count_n != '0);
    end
  end

  // storage array; stale entries are harmless since pointers gate them
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/kbd_event_queue.sv
// PS/2 scancode parser feeding an event FIFO. Prefix bytes E0/F0 are folded
// into ext/release flags on the following code byte.
// Optional macro KBD_TYPEMATIC_FILTER_EN: drops auto-repeat makes of the
// currently held key.
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_release,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        overflow
);

  kbd_state_t state, state_n;
  logic       emit, push, full, empty;
  kbd_evt_t   evt, head;

  // parser state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // parser next state; a non-prefix byte always emits and returns to IDLE
  always_comb begin
    state_n  = state;
    emit     = 1'b0;
    evt.code = rx_data;
    evt.ext  = (state == EXT) || (state == EXT_BRK);
    evt.rel  = (state == BRK) || (state == EXT_BRK);
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if      (rx_data == KBD_PREFIX_EXT) state_n = EXT;
          else if (rx_data == KBD_PREFIX_BRK) state_n = BRK;
          else                                emit    = 1'b1;
        end
        EXT: begin
          if      (rx_data == KBD_PREFIX_BRK) state_n = EXT_BRK;
          else if (rx_data != KBD_PREFIX_EXT) emit    = 1'b1;
        end
        BRK: begin
          if      (rx_data == KBD_PREFIX_EXT) state_n = EXT_BRK;
          else if (rx_data != KBD_PREFIX_BRK) emit    = 1'b1;
        end
        EXT_BRK: begin
          if ((rx_data != KBD_PREFIX_EXT) && (rx_data != KBD_PREFIX_BRK))
            emit = 1'b1;
        end
        default: state_n = IDLE;
      endcase
      if (emit) state_n = IDLE;
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       held_valid, held_ext, held_match;
  logic [7:0] held_code;

  assign held_match = held_valid && (held_code == evt.code) && (held_ext == evt.ext);
  // repeats of the held key vanish silently; everything else is queued
  assign push = emit && !(held_match && !evt.rel);

  // held-key tracking: new makes take over, a matching break releases
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_code  <= '0;
      held_ext   <= 1'b0;
    end else if (emit) begin
      if (!evt.rel) begin
        if (!held_match) begin
          held_valid <= 1'b1;
          held_code  <= evt.code;
          held_ext   <= evt.ext;
        end
      end else if (held_match) begin
        held_valid <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  kbd_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (CLOCK_50),
    .reset      (reset),
    .push       (push),
    .din        (evt),
    .pop        (evt_ready),
    .full       (full),
    .empty      (empty),
    .count      (evt_count),
    .head       (head),
    .head_valid (evt_valid)
  );

  assign evt_code    = head.code;
  assign evt_ext     = head.ext;
  assign evt_release = head.rel;

  // sticky drop flag: push into a full FIFO that is not popping this edge
  always_ff @(posedge CLOCK_50) begin
    if (reset)                                 overflow <= 1'b0;
    else if (push && full && !(evt_ready && !empty)) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Bench for kbd_event_queue: directed scenarios with literal expectations
// plus randomized byte streams checked every cycle against a queue model.
module tb_kbd_event_queue;

  localparam int DEPTH = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ext, evt_release, overflow;
  logic [7:0] evt_code;
  logic [$clog2(DEPTH):0] evt_count;

  int n_chk = 0;
  int n_err = 0;

  kbd_event_queue #(.FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_release (evt_release),
    .evt_count   (evt_count),
    .overflow    (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // reference model: pending prefix flags, event queue, sticky drop, held key
  bit         m_ext, m_brk, m_ovf;
  logic [9:0] m_q[$];
  bit         h_v, h_ext;
  logic [7:0] h_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // apply one edge of the spec rules to the model, using the current inputs
  task automatic model_edge();
    bit         pop, keep, e, b;
    logic [9:0] ev;
    if (reset) begin
      m_ext = 0; m_brk = 0; m_ovf = 0; h_v = 0; m_q.delete();
      return;
    end
    pop  = (m_q.size() != 0) && evt_ready;
    keep = 0;
    ev   = '0;
    if (rx_valid) begin
      if (rx_data == 8'hE0)      m_ext = 1;
      else if (rx_data == 8'hF0) m_brk = 1;
      else begin
        e = m_ext; b = m_brk;
        ev = {rx_data, e, b};
        keep = 1;
        m_ext = 0; m_brk = 0;
`ifdef KBD_TYPEMATIC_FILTER_EN
        if (!b) begin
          if (h_v && h_code == rx_data && h_ext == e) keep = 0;
          else begin h_v = 1; h_code = rx_data; h_ext = e; end
        end else if (h_v && h_code == rx_data && h_ext == e) h_v = 0;
`endif
      end
    end
    if (pop) void'(m_q.pop_front());
    if (keep) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev);
      else                    m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    chk("valid", evt_valid, m_q.size() != 0);
    chk("count", evt_count, m_q.size());
    chk("overflow", overflow, m_ovf);
    if (m_q.size() != 0) chk("head", {evt_code, evt_ext, evt_release}, m_q[0]);
  endtask

  // one clock: drive inputs, advance model at the edge, compare just after
  task automatic step(input logic v, input logic [7:0] d, input logic rdy, input logic rst);
    rx_valid = v; rx_data = d; evt_ready = rdy; reset = rst;
    @(posedge CLOCK_50);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
  endtask

  logic [7:0] seq[6];
  int         n_exp;

  initial begin
    // reset state
    step(1, 8'h1C, 1, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_code", {evt_code, evt_ext, evt_release}, 0);

    // single make, visible one cycle after the strobe
    step(1, 8'h1C, 0, 0);
    chk("make_valid", evt_valid, 1);
    chk("make_evt", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b00});
    step(0, 8'h00, 1, 0);
    chk("make_drained", evt_count, 0);

    // extended break
    step(1, 8'hE0, 1, 0);
    step(1, 8'hF0, 1, 0);
    step(1, 8'h75, 1, 0);
    chk("extbrk_evt", {evt_code, evt_ext, evt_release}, {8'h75, 2'b11});
    chk("extbrk_count", evt_count, 1);
    step(0, 8'h00, 1, 0);
    chk("extbrk_drained", evt_count, 0);

    // nine makes into depth 8: overflow and ordered drain
    for (int i = 1; i <= 9; i++) step(1, 8'(i), 0, 0);
    chk("ovf_count", evt_count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", evt_code, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_code", evt_code, i);
      step(0, 8'h00, 1, 0);
    end
    chk("drain_empty", evt_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // full FIFO, push with pop on same edge
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 8'h11 + 8'(i), 0, 0);
    step(1, 8'h19, 1, 0);
    chk("fullpp_count", evt_count, 8);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", evt_code, 8'h12);

    // prefix discarded by reset, rx_valid during reset ignored
    do_reset();
    step(1, 8'hE0, 0, 0);
    step(1, 8'h2A, 0, 1);
    step(1, 8'h1C, 0, 0);
    chk("rstpfx_count", evt_count, 1);
    chk("rstpfx_evt", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b00});

    // typematic sequence
    do_reset();
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    foreach (seq[i]) step(1, seq[i], 0, 0);
`ifdef KBD_TYPEMATIC_FILTER_EN
    n_exp = 3;
    chk("typ_count", evt_count, 3);
    chk("typ_e0", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b00}); step(0, 0, 1, 0);
    chk("typ_e1", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b01}); step(0, 0, 1, 0);
    chk("typ_e2", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b00}); step(0, 0, 1, 0);
`else
    n_exp = 5;
    chk("typ_count", evt_count, 5);
    for (int i = 0; i < 3; i++) begin
      chk("typ_mk", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b00}); step(0, 0, 1, 0);
    end
    chk("typ_brk", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b01}); step(0, 0, 1, 0);
    chk("typ_mk2", {evt_code, evt_ext, evt_release}, {8'h1C, 2'b00}); step(0, 0, 1, 0);
`endif
    chk("typ_empty", evt_count, 0);

    // randomized stream: prefix-heavy bytes from a small code set
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic       v, r, rs;
      logic [7:0] d;
      int         k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    d = 8'hE0;
        2, 3:    d = 8'hF0;
        4:       d = 8'hE1;
        default: d = 8'h1C + 8'($urandom_range(0, 3));
      endcase
      v  = ($urandom_range(0, 2) != 0);
      r  = (c % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 299) == 0);
      step(v, d, r, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/kbd_event_queue.md
KBD_EVENT_QUEUE -- requirements
Module: kbd_event_queue

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO depth; SHALL be a power of two, 2..64.
REQ-002 CLOCK_50  input  1  sole clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_data  input  8  PS/2 byte from the PS/2 receive controller.
REQ-005 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 evt_valid  output  1  FIFO head holds an event.
REQ-007 evt_ready  input  1  consumer accepts the head event.
REQ-008 evt_code  output  8  scancode of the head event.
REQ-009 evt_ext  output  1  head event was 0xE0-prefixed.
REQ-010 evt_release  output  1  head event is a break (key up); 0 means make.
REQ-011 evt_count  output  $clog2(FIFO_DEPTH)+1  number of queued events.
REQ-012 overflow  output  1  sticky: an event was dropped because the FIFO was full.

Function
REQ-013 The parser FSM SHALL have four states: IDLE, EXT, BRK, EXT_BRK; bytes are consumed only on cycles with rx_valid=1.
REQ-014 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte -> emit {code, ext=0, rel=0}, stay in IDLE.
REQ-015 EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay in EXT; any other byte -> emit {code, 1, 0}, go to IDLE.
REQ-016 BRK: 0xF0 -> stay in BRK; 0xE0 -> EXT_BRK; any other byte -> emit {code, 0, 1}, go to IDLE.
REQ-017 EXT_BRK: 0xE0 or 0xF0 -> stay in EXT_BRK; any other byte -> emit {code, 1, 1}, go to IDLE.
REQ-018 0xE1 and all other codes SHALL have no special meaning.
REQ-019 An emitted event SHALL be written to the FIFO on the rising edge that ends the rx_valid cycle.
REQ-020 With an empty FIFO, evt_valid SHALL go high exactly 1 cycle after the final byte's rx_valid cycle.
REQ-021 Head outputs SHALL be registered FIFO contents and SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-022 A pop SHALL occur on any cycle with evt_valid=1 and evt_ready=1; evt_ready SHALL be ignored while evt_valid=0.
REQ-023 Push and pop on the same cycle SHALL both take effect, leaving evt_count unchanged.
REQ-024 Full FIFO with a push and a pop on the same cycle: the push SHALL be accepted.
REQ-025 Full FIFO with a push and no pop: the event SHALL be dropped, overflow set to 1, FIFO contents unchanged, and the FSM SHALL still advance to IDLE.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 evt_count SHALL range 0..FIFO_DEPTH.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 On reset the following SHALL apply on the next edge:
- FSM -> IDLE
- pointers and evt_count -> 0
- evt_valid, evt_code, evt_ext, evt_release, overflow -> 0
- typematic held state cleared
REQ-030 A partial prefix sequence in progress at reset SHALL be discarded.
REQ-031 An rx_valid asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-032 Macro KBD_TYPEMATIC_FILTER_EN defined:
- a held-key register {valid, code, ext} SHALL be kept
- a make event matching the held key SHALL be dropped without setting overflow
- any other make SHALL be enqueued and SHALL replace the held key
- a break matching the held key SHALL clear valid
- all breaks SHALL be enqueued
REQ-033 Macro KBD_TYPEMATIC_FILTER_EN undefined: every parsed event SHALL be enqueued and no held-key logic SHALL exist.

Structure
REQ-034 Package kbd_pkg SHALL hold:
- constants KBD_PREFIX_EXT=8'hE0 and KBD_PREFIX_BRK=8'hF0
- the parser state enumeration
- the 10-bit event type {code, ext, release}
REQ-035 FIFO storage and pointers SHALL be a sub-module kbd_event_fifo (synchronous, registered output, full/empty/count); parser and filter SHALL reside in kbd_event_queue.

Verification
REQ-036 Input 1C -> one event {1C,0,0}; evt_valid high 1 cycle after the strobe.
REQ-037 Input E0 F0 75, evt_ready=1 -> single event {75,1,1}; evt_count returns to 0.
REQ-038 Input 9 make codes with FIFO_DEPTH=8 and evt_ready=0 -> evt_count=8, overflow=1, head=first code; drain yields codes 1..8 in order.
REQ-039 Full FIFO with a push and evt_ready=1 on the same cycle -> count stays 8 and overflow stays 0.
REQ-040 Input E0 then reset then 1C -> event {1C,0,0}; no ext flag.
REQ-041 With KBD_TYPEMATIC_FILTER_EN, input 1C 1C 1C F0 1C 1C -> events {1C,0,0}, {1C,0,1}, {1C,0,0}; without the macro, all 5 events.
